// File: rtl/reg_file_clr_if.sv
// Bus bundle for reg_file_clr: write port, two read ports and the clear handshake.
interface reg_file_clr_if #(
    parameter int W     = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr_a;
    logic [W-1:0]  rdata_a;
    logic [AW-1:0] raddr_b;
    logic [W-1:0]  rdata_b;
    logic          clear_req;
    logic          busy;
    logic          clear_done;
    logic          wr_drop;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clear_req,
        input  rdata_a, rdata_b, busy, clear_done, wr_drop
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clear_req,
        output rdata_a, rdata_b, busy, clear_done, wr_drop
    );
endinterface

// File: rtl/reg_file_clr.sv
// DEPTH x W register file: one write port, two registered read ports with
// write-through bypass, and a one-entry-per-cycle bulk clear behind busy.
module reg_file_clr #(
    parameter int  W     = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    reg_file_clr_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    // Address range limits, sized so out-of-range codes compare correctly
    // when DEPTH is not a power of two.
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [AW-1:0] ptr_reg;
    logic [W-1:0]  entry [DEPTH];
    logic [W-1:0]  rdata_a_reg;
    logic [W-1:0]  rdata_b_reg;
    logic [W-1:0]  rdata_a_next;
    logic [W-1:0]  rdata_b_next;
    logic          wr_drop_reg;
    logic          wr_accept;
    logic          ptr_last;

    assign ptr_last  = (ptr_reg == LAST_PTR);
    // A pending clear request outranks a write on the same edge.
    assign wr_accept = bus.we && (state_reg == IDLE) && !bus.clear_req &&
                       ({1'b0, bus.waddr} < DEPTH_C);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic: IDLE -> SWEEP on request, SWEEP until last entry, one DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.clear_req) state_next = SWEEP;
            SWEEP:   if (ptr_last)      state_next = DONE;
            DONE:                       state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        bus.busy       = (state_reg != IDLE);
        bus.clear_done = (state_reg == DONE);
    end

    // Clear pointer: parked at 0 outside SWEEP, wraps at DEPTH-1 so unused codes are never visited.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                ptr_reg <= '0;
        else if (state_reg == SWEEP) ptr_reg <= ptr_last ? '0 : ptr_reg + 1'b1;
        else                         ptr_reg <= '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry storage: sweep zeroing, otherwise an accepted write.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    entry[gi] <= '0;
                else if (state_reg == SWEEP && ptr_reg == AW'(gi))
                    entry[gi] <= '0;
                else if (wr_accept && bus.waddr == AW'(gi))
                    entry[gi] <= bus.wdata;
            end
        end
    endgenerate

    // Port A read data: zero while clearing or out of range, bypass a same-edge write.
    always_comb begin
        rdata_a_next = '0;
        if (state_reg == IDLE && ({1'b0, bus.raddr_a} < DEPTH_C)) begin
            if (wr_accept && bus.waddr == bus.raddr_a) rdata_a_next = bus.wdata;
            else                                       rdata_a_next = entry[bus.raddr_a];
        end
    end

    // Port B read data: same rules as port A.
    always_comb begin
        rdata_b_next = '0;
        if (state_reg == IDLE && ({1'b0, bus.raddr_b} < DEPTH_C)) begin
            if (wr_accept && bus.waddr == bus.raddr_b) rdata_b_next = bus.wdata;
            else                                       rdata_b_next = entry[bus.raddr_b];
        end
    end

    // Registered read data and the dropped-write pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            rdata_a_reg <= rdata_a_next;
            rdata_b_reg <= rdata_b_next;
            wr_drop_reg <= bus.we && ((state_reg != IDLE) || bus.clear_req);
        end
    end

    assign bus.rdata_a = rdata_a_reg;
    assign bus.rdata_b = rdata_b_reg;
    assign bus.wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_reg_file_clr.sv
// Scoreboard bench for reg_file_clr: an 8x8 instance and a 5x16 instance.
module tb_reg_file_clr;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_clr_if #(.W(8),  .DEPTH(8)) bus0 ();
    reg_file_clr_if #(.W(16), .DEPTH(5)) bus1 ();

    reg_file_clr #(.W(8),  .DEPTH(8)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    reg_file_clr #(.W(16), .DEPTH(5)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    typedef enum int {S_RA, S_RB, S_BUSY, S_DONE, S_DROP, T_RA, T_BUSY, T_DONE, T_DROP} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sel;
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(sig_e s);
        case (s)
            S_RA:    return {8'h00, bus0.rdata_a};
            S_RB:    return {8'h00, bus0.rdata_b};
            S_BUSY:  return {15'h0, bus0.busy};
            S_DONE:  return {15'h0, bus0.clear_done};
            S_DROP:  return {15'h0, bus0.wr_drop};
            T_RA:    return bus1.rdata_a;
            T_BUSY:  return {15'h0, bus1.busy};
            T_DONE:  return {15'h0, bus1.clear_done};
            T_DROP:  return {15'h0, bus1.wr_drop};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Expected value for the output seen after 'off' more edges.
    task automatic push(input sig_e s, input string nm, input logic [15:0] v, input int off);
        exp_t e;
        e.cyc  = cyc + off;
        e.sel  = s;
        e.name = nm;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due in this cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_checks++;
                if (sb[i].cyc < cyc)
                    $display("FAIL %s: expectation for cycle %0d never compared", sb[i].name, sb[i].cyc);
                else if (actual(sb[i].sel) === sb[i].exp) begin
                    n_pass++;
                    $display("ok   %s cyc=%0d value=%h", sb[i].name, cyc, sb[i].exp);
                end else
                    $display("FAIL %s cyc=%0d: got %h, want %h", sb[i].name, cyc, actual(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    int e0;

    initial begin
        bus0.we = 0; bus0.waddr = '0; bus0.wdata = '0; bus0.raddr_a = '0; bus0.raddr_b = '0; bus0.clear_req = 0;
        bus1.we = 0; bus1.waddr = '0; bus1.wdata = '0; bus1.raddr_a = '0; bus1.raddr_b = '0; bus1.clear_req = 0;

        // Reset state of both instances.
        tick(); tick();
        push(S_RA, "rst_ra", 0, 0);   push(S_RB, "rst_rb", 0, 0);
        push(S_BUSY, "rst_busy", 0, 0); push(S_DONE, "rst_done", 0, 0); push(S_DROP, "rst_drop", 0, 0);
        push(T_RA, "rst1_ra", 0, 0);  push(T_BUSY, "rst1_busy", 0, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Write 0xA5 to addr 3 while reading unwritten addr 5, then read addr 3 on both ports.
        bus0.we = 1; bus0.waddr = 3; bus0.wdata = 8'hA5; bus0.raddr_a = 5; bus0.raddr_b = 5;
        push(S_RA, "unwritten_a", 8'h00, 1); push(S_RB, "unwritten_b", 8'h00, 1);
        tick();
        bus0.we = 0; bus0.raddr_a = 3; bus0.raddr_b = 3;
        push(S_RA, "read3_a", 8'hA5, 1); push(S_RB, "read3_b", 8'hA5, 1);
        tick();

        // Bypass: addr 2 holds 0x11, same-edge write of 0x3C must be seen.
        bus0.we = 1; bus0.waddr = 2; bus0.wdata = 8'h11;
        tick();
        bus0.wdata = 8'h3C; bus0.raddr_a = 2; bus0.raddr_b = 2;
        push(S_RA, "bypass_a", 8'h3C, 1); push(S_RB, "bypass_b", 8'h3C, 1);
        tick();
        bus0.we = 0;
        push(S_RA, "after_bypass", 8'h3C, 1);
        tick();

        // Fill all entries with 0x10+i.
        for (int i = 0; i < 8; i++) begin
            bus0.we = 1; bus0.waddr = 3'(i); bus0.wdata = 8'(8'h10 + i); bus0.raddr_a = 3'(i);
            push(S_RA, "fill", 16'(8'h10 + i), 1);
            tick();
        end
        bus0.we = 0; bus0.raddr_a = 7; bus0.raddr_b = 0;
        push(S_RA, "fill_rd7", 8'h17, 1); push(S_RB, "fill_rd0", 8'h10, 1);
        tick();

        // Single clear pulse: busy 9 cycles, clear_done once, reads forced to 0.
        bus0.clear_req = 1;
        for (int j = 1; j <= 11; j++) begin
            push(S_RA, "clr_ra", (j == 1) ? 16'h17 : 16'h0, j);
            push(S_RB, "clr_rb", (j == 1) ? 16'h10 : 16'h0, j);
        end
        for (int j = 1; j <= 10; j++) begin
            push(S_BUSY, "clr_busy", (j <= 9) ? 16'h1 : 16'h0, j);
            push(S_DONE, "clr_done", (j == 9) ? 16'h1 : 16'h0, j);
        end
        tick();
        bus0.clear_req = 0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            bus0.raddr_a = 3'(i);
            push(S_RA, "cleared", 8'h00, 1);
            tick();
        end

        // Dropped writes: one alongside clear_req, one mid-sweep into an already-cleared entry.
        bus0.we = 1; bus0.waddr = 4; bus0.wdata = 8'hEE; bus0.clear_req = 1;
        push(S_DROP, "drop_req", 1, 1); push(S_DROP, "drop_req_end", 0, 2);
        tick();
        bus0.we = 0; bus0.clear_req = 0;
        tick(); tick();
        bus0.we = 1; bus0.waddr = 0; bus0.wdata = 8'h77;
        push(S_DROP, "drop_sweep", 1, 1); push(S_DROP, "drop_sweep_end", 0, 2);
        tick();
        bus0.we = 0;
        repeat (7) tick();
        bus0.raddr_a = 0; bus0.raddr_b = 4;
        push(S_RA, "dropped_0", 8'h00, 1); push(S_RB, "dropped_4", 8'h00, 1);
        push(S_BUSY, "drop_idle", 0, 1);
        tick();

        // Reset in the middle of a sweep.
        bus0.we = 1; bus0.waddr = 7; bus0.wdata = 8'h99;
        tick();
        bus0.we = 0; bus0.clear_req = 1;
        tick();
        bus0.clear_req = 0;
        repeat (3) tick();
        reset_n = 1'b0;
        push(S_BUSY, "rst_mid_busy", 0, 0); push(S_DONE, "rst_mid_done", 0, 0);
        push(S_DROP, "rst_mid_drop", 0, 0); push(S_RA, "rst_mid_ra", 0, 0); push(S_RB, "rst_mid_rb", 0, 0);
        for (int j = 1; j <= 10; j++) push(S_DONE, "rst_no_done", 0, j);
        for (int j = 1; j <= 3; j++)  push(S_BUSY, "rst_no_busy", 0, j);
        tick(); tick();
        reset_n = 1'b1;
        bus0.we = 1; bus0.waddr = 3; bus0.wdata = 8'hC3; bus0.raddr_a = 7;
        push(S_RA, "rst_entry7", 8'h00, 1); push(S_DROP, "rst_wr_nodrop", 0, 1);
        tick();
        bus0.we = 0; bus0.raddr_a = 3;
        push(S_RA, "post_rst_wr", 8'hC3, 1);
        tick();
        repeat (8) tick();

        // DEPTH=5 instance: out-of-range write and read, back-to-back clears.
        bus1.we = 1; bus1.waddr = 2; bus1.wdata = 16'h1234;
        tick();
        bus1.waddr = 6; bus1.wdata = 16'hBEEF; bus1.raddr_a = 7;
        push(T_DROP, "oor_wr_nodrop", 0, 1); push(T_RA, "oor_rd7", 0, 1);
        tick();
        bus1.we = 0; bus1.raddr_a = 2;
        push(T_RA, "d5_read2", 16'h1234, 1);
        tick();
        e0 = cyc;
        bus1.clear_req = 1;
        for (int j = 1; j <= 14; j++) begin
            push(T_BUSY, "d5_busy", ((j <= 6) || (j >= 8 && j <= 13)) ? 16'h1 : 16'h0, j);
            push(T_DONE, "d5_done", ((j == 6) || (j == 13)) ? 16'h1 : 16'h0, j);
        end
        push(T_RA, "d5_busy_rd", 0, 2);
        repeat (8) tick();
        bus1.clear_req = 0;
        repeat (7) tick();
        push(T_RA, "d5_cleared2", 0, 1);
        tick();

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        while (sb.size() > 0) begin
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d still pending at end", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_clr.md
# reg_file_clr

Parametrised multi-entry successor to the single load/clear register: a DEPTH x W register file with one write port, two registered read ports with write-through bypass, and a sequenced bulk clear that zeroes one entry per cycle under a busy handshake. Sits in the datapath wherever several loadable registers were previously instantiated individually, e.g. accumulator banks and operand staging.

## Interface
- W, default 8: data width of each entry.
- DEPTH, default 8: number of entries, at least 2; need not be a power of two.
- AW, default $clog2(DEPTH): address width, derived and not overridden.
- clk  in  1  the single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  W  write data.
- raddr_a  in  AW  read port A address.
- rdata_a  out  W  read port A data, registered.
- raddr_b  in  AW  read port B address.
- rdata_b  out  W  read port B data, registered.
- clear_req  in  1  request a bulk clear, level-sampled.
- busy  out  1  clear sequence in progress; writes are not accepted.
- clear_done  out  1  one-cycle pulse marking the end of a clear.
- wr_drop  out  1  one-cycle pulse: a write was presented and discarded.

## Operation
- Reset (reset_n=0, asynchronous):
  - all entries become 0;
  - FSM returns to IDLE and the clear pointer to 0;
  - rdata_a, rdata_b, busy, clear_done and wr_drop all become 0.
- FSM states:
  - IDLE: normal operation.
    - clear_req=1 -> SWEEP with ptr=0.
  - SWEEP: at each edge, entry[ptr] <= 0 and ptr increments.
    - Leaves for DONE on the edge that clears entry DEPTH-1.
    - clear_req is ignored in this state.
  - DONE: one cycle, then -> IDLE.
    - clear_req is ignored in this state.
- Output decode:
  - busy = (state != IDLE).
  - clear_done = (state == DONE).
- Writes:
  - Accepted only when state==IDLE, clear_req=0 and waddr<DEPTH. Then entry[waddr] <= wdata.
  - we=1 with state!=IDLE, or with clear_req=1 in IDLE -> write discarded and wr_drop=1 for the following cycle. Clear has priority over a simultaneous write.
  - we=1 with waddr>=DEPTH -> silently ignored; no wr_drop.
- Reads (each port independent, evaluated at every edge):
  - state!=IDLE -> rdata <= 0.
  - Otherwise, raddr>=DEPTH -> rdata <= 0.
  - Otherwise, an accepted write to raddr on the same edge -> rdata <= wdata (bypass).
  - Otherwise rdata <= entry[raddr].
- The clear pointer has AW bits and never exceeds DEPTH-1. Unused codes are not visited when DEPTH is not a power of two.

## Timing
- Write-to-storage latency: 1 edge.
- Read latency: 1 edge, address to rdata. The bypass makes a same-edge write visible with the same 1-edge latency.
- Clear with clear_req first sampled high at edge k in IDLE:
  - busy=1 from after edge k through edge k+DEPTH+1;
  - entry i is zeroed at edge k+1+i;
  - clear_done=1 for exactly the cycle between edges k+DEPTH and k+DEPTH+1;
  - busy=0 and writes are accepted again from edge k+DEPTH+2.
  - Total busy duration is DEPTH+1 cycles.
- clear_req held high continuously restarts a clear on the first edge back in IDLE. Back-to-back clears therefore have exactly one IDLE cycle between them.
- reset_n asserted mid-sweep aborts the sequence immediately and zeroes everything. No clear_done pulse is produced.
- Reset deassertion is synchronised externally; the block makes no assumption beyond that.

## Test plan
- Reset, then write 0xA5 to addr 3; read A=3 and B=3 next cycle -> both 0xA5 one edge later. Unwritten addr 5 reads 0x00.
- Same-edge write 0x3C to addr 2 with raddr_a=2 -> rdata_a=0x3C after that edge (bypass), not the old value.
- Fill all 8 entries, pulse clear_req at edge k:
  - busy is high for 9 cycles and clear_done pulses once after edge k+8;
  - reads during busy return 0 and all entries read 0x00 afterwards.
- we=1 with clear_req=1 in IDLE, and we=1 mid-sweep -> wr_drop pulses one cycle each; the written entry is 0 after the sweep.
- Assert reset_n=0 at sweep step 4 -> all outputs 0 immediately, state IDLE, no clear_done; a write right after deassertion is accepted.
- DEPTH=5, W=16: write to addr 6 is ignored with no wr_drop; read of addr 7 returns 0; a clear lasts 6 busy cycles and ptr never exceeds 4.
